// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_SC     = 2'b11;

  // Branch condition against the registered flags (pre-update values).
  function automatic logic cond_met(input logic [1:0] sel, input logic zero_q, input logic sc_q);
    logic ok;
    case (sel)
      COND_ALWAYS: ok = 1'b1;
      COND_Z:      ok = zero_q;
      COND_NZ:     ok = ~zero_q;
      default:     ok = sc_q;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/prog_sequencer_jump_lut.sv
// Writable jump table: one registered write port, one combinational read
// port. A read of the index being written returns the pre-write value,
// because the write only lands on the clock edge.
module jump_lut
  import prog_seq_pkg::*;
#(
  parameter  int D     = 12,
  parameter  int LUT_N = 4,
  localparam int LW    = (LUT_N > 1) ? $clog2(LUT_N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [LW-1:0] wr_idx,
  input  logic [D-1:0]  wr_data,
  input  logic [LW-1:0] rd_idx,
  output logic [D-1:0]  rd_data,
  output logic          rd_valid
);

  // Entry count widened by one bit so power-of-two sizes compare correctly.
  localparam logic [LW:0] N_L = LUT_N[LW:0];

  logic [D-1:0] entries [LUT_N];

  genvar gi;
  generate
    for (gi = 0; gi < LUT_N; gi++) begin : g_entry
      logic [D-1:0] entry_q;

      // Per-entry storage, cleared by reset, loaded when its index is written.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_q <= '0;
        end else if (wr_en && (wr_idx == LW'(gi))) begin
          entry_q <= wr_data;
        end
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  // Indices past the populated range read as invalid (and zero).
  always_comb begin
    rd_valid = ({1'b0, rd_idx} < N_L);
    rd_data  = '0;
    if (rd_valid) begin
      rd_data = entries[rd_idx];
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: PC register with run handshake, conditional
// absolute/relative branching, registered ALU flags and a run-cycle counter.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter  int D        = 12,
  parameter  int LUT_N    = 4,
  parameter  int END_ADDR = 128,
  parameter  int CW       = 16,
  localparam int LW       = (LUT_N > 1) ? $clog2(LUT_N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  start_addr,
  input  logic          halt,
  input  logic          abs_br,
  input  logic          rel_br,
  input  logic [1:0]    cond_sel,
  input  logic [LW-1:0] lut_sel,
  input  logic [D-1:0]  rel_off,
  input  logic          jt_wr_en,
  input  logic [LW-1:0] jt_wr_idx,
  input  logic [D-1:0]  jt_wr_data,
  input  logic          zero_i,
  input  logic          pari_i,
  input  logic          sc_i,
  input  logic          flag_en,
  input  logic          sc_clr,
  input  logic          sc_en,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic          zeroQ,
  output logic          pariQ,
  output logic          scQ,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [D-1:0] END_PC = END_ADDR[D-1:0];

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic          pari_q, pari_d;
  logic          sc_q, sc_d;

  logic [D-1:0]  jt_data;
  logic          jt_valid;
  logic          cond_ok;
  logic          abs_taken;
  logic          rel_taken;
  logic [D-1:0]  next_pc;
  logic          end_hit;

  jump_lut #(
    .D     (D),
    .LUT_N (LUT_N)
  ) u_jump_lut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (jt_wr_en),
    .wr_idx   (jt_wr_idx),
    .wr_data  (jt_wr_data),
    .rd_idx   (lut_sel),
    .rd_data  (jt_data),
    .rd_valid (jt_valid)
  );

  // Next-state, next-PC, flag and counter logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    pari_d  = pari_q;
    sc_d    = sc_q;

    cond_ok   = cond_met(cond_sel, zero_q, sc_q);
    abs_taken = abs_br && cond_ok && jt_valid;
    rel_taken = rel_br && cond_ok;

    if (abs_taken) begin
      next_pc = jt_data;
    end else if (rel_taken) begin
      next_pc = pc_q + rel_off;
    end else begin
      next_pc = pc_q + D'(1);
    end

    // A run ends when the PC is about to reach END_ADDR, or when it already
    // sits on END_ADDR (start_addr == END_ADDR) and nothing branches away.
    end_hit = (next_pc == END_PC) || ((pc_q == END_PC) && !abs_taken && !rel_taken);

    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          state_d = RUN;
          pc_d    = start_addr;
          cnt_d   = '0;
          zero_d  = 1'b0;
          pari_d  = 1'b0;
          sc_d    = 1'b0;
        end
      end
      RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        if (flag_en) begin
          zero_d = zero_i;
          pari_d = pari_i;
        end
        if (sc_clr) begin
          sc_d = 1'b0;
        end else if (sc_en) begin
          sc_d = sc_i;
        end
        if (halt) begin
          state_d = DONE;
        end else if (end_hit) begin
          state_d = DONE;
          pc_d    = END_PC;
        end else begin
          pc_d = next_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC, flag and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      pari_q  <= 1'b0;
      sc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      pari_q  <= pari_d;
      sc_q    <= sc_d;
    end
  end

  assign prog_ctr  = pc_q;
  assign running   = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign zeroQ     = zero_q;
  assign pariQ     = pari_q;
  assign scQ       = sc_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Testbench for prog_sequencer: directed scenarios plus randomized runs,
// checked against a cycle-level behavioural model.
module tb_prog_sequencer;

  localparam int D        = 12;
  localparam int LUT_N    = 3;
  localparam int LW       = 2;
  localparam int END_ADDR = 128;
  localparam int CW       = 4;
  localparam int PC_MOD   = 4096;
  localparam int CNT_MAX  = 15;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_DONE   = 2;

  logic          clk;
  logic          reset;
  logic          req;
  logic [D-1:0]  start_addr;
  logic          halt;
  logic          abs_br;
  logic          rel_br;
  logic [1:0]    cond_sel;
  logic [LW-1:0] lut_sel;
  logic [D-1:0]  rel_off;
  logic          jt_wr_en;
  logic [LW-1:0] jt_wr_idx;
  logic [D-1:0]  jt_wr_data;
  logic          zero_i, pari_i, sc_i;
  logic          flag_en, sc_clr, sc_en;
  logic [D-1:0]  prog_ctr;
  logic          running, done;
  logic          zeroQ, pariQ, scQ;
  logic [CW-1:0] cycle_cnt;

  int n_checks;
  int n_fail;

  // Behavioural model state
  int m_state, m_pc, m_cnt, m_z, m_p, m_sc;
  int m_jt [LUT_N];

  prog_sequencer #(
    .D(D), .LUT_N(LUT_N), .END_ADDR(END_ADDR), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .start_addr(start_addr),
    .halt(halt), .abs_br(abs_br), .rel_br(rel_br), .cond_sel(cond_sel),
    .lut_sel(lut_sel), .rel_off(rel_off), .jt_wr_en(jt_wr_en),
    .jt_wr_idx(jt_wr_idx), .jt_wr_data(jt_wr_data), .zero_i(zero_i),
    .pari_i(pari_i), .sc_i(sc_i), .flag_en(flag_en), .sc_clr(sc_clr),
    .sc_en(sc_en), .prog_ctr(prog_ctr), .running(running), .done(done),
    .zeroQ(zeroQ), .pariQ(pariQ), .scQ(scQ), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_pc = 0; m_cnt = 0; m_z = 0; m_p = 0; m_sc = 0;
    for (int i = 0; i < LUT_N; i++) m_jt[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int off, npc;
    bit ok, abs_t, rel_t;
    int jt_next [LUT_N];
    jt_next = m_jt;
    if (jt_wr_en && int'(jt_wr_idx) < LUT_N) jt_next[jt_wr_idx] = int'(jt_wr_data);
    if (m_state != M_RUN) begin
      if (req) begin
        m_state = M_RUN; m_pc = int'(start_addr); m_cnt = 0;
        m_z = 0; m_p = 0; m_sc = 0;
      end
    end else begin
      case (cond_sel)
        2'b00:   ok = 1'b1;
        2'b01:   ok = (m_z != 0);
        2'b10:   ok = (m_z == 0);
        default: ok = (m_sc != 0);
      endcase
      abs_t = abs_br && ok && (int'(lut_sel) < LUT_N);
      rel_t = rel_br && ok;
      off = rel_off[D-1] ? int'(rel_off) - PC_MOD : int'(rel_off);
      if (halt) begin
        m_state = M_DONE;
      end else begin
        if (abs_t)      npc = m_jt[lut_sel];
        else if (rel_t) npc = (m_pc + off + PC_MOD) % PC_MOD;
        else            npc = (m_pc + 1) % PC_MOD;
        if (npc == END_ADDR || (m_pc == END_ADDR && !abs_t && !rel_t)) begin
          m_state = M_DONE; m_pc = END_ADDR;
        end else begin
          m_pc = npc;
        end
      end
      if (m_cnt < CNT_MAX) m_cnt++;
      if (flag_en) begin m_z = int'(zero_i); m_p = int'(pari_i); end
      if (sc_clr) m_sc = 0;
      else if (sc_en) m_sc = int'(sc_i);
    end
    m_jt = jt_next;
  endtask

  task automatic compare_all();
    check_eq("prog_ctr",  32'(prog_ctr),  32'(m_pc));
    check_eq("running",   32'(running),   32'(m_state == M_RUN));
    check_eq("done",      32'(done),      32'(m_state == M_DONE));
    check_eq("flags",     {29'd0, zeroQ, pariQ, scQ}, 32'((m_z << 2) | (m_p << 1) | m_sc));
    check_eq("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
  endtask

  task automatic tick();
    int prev;
    prev = m_state;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (prev == M_RUN && m_state == M_DONE)
      $display("run ended: pc=%0d cycles=%0d", m_pc, m_cnt);
  endtask

  task automatic idle_inputs();
    req = 0; halt = 0; abs_br = 0; rel_br = 0; cond_sel = 2'b00; lut_sel = '0;
    rel_off = '0; jt_wr_en = 0; jt_wr_idx = '0; jt_wr_data = '0;
    zero_i = 0; pari_i = 0; sc_i = 0; flag_en = 0; sc_clr = 0; sc_en = 0;
  endtask

  task automatic jt_write(input int idx, input int data);
    jt_wr_en = 1; jt_wr_idx = LW'(idx); jt_wr_data = D'(data);
    tick();
    jt_wr_en = 0;
  endtask

  task automatic start_run(input int addr);
    start_addr = D'(addr); req = 1;
    tick();
    req = 0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    idle_inputs();
    start_addr = '0;
    reset = 0;
    model_reset();
    #2;
    compare_all();
    $display("reset state checked");
    @(negedge clk);
    reset = 1;

    // Linear run from 120 to END_ADDR
    start_run(120);
    check_eq("t1_start_pc", 32'(prog_ctr), 32'd120);
    repeat (8) tick();
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_pc", 32'(prog_ctr), 32'd128);
    check_eq("t1_cnt", 32'(cycle_cnt), 32'd8);

    // Table fill while in DONE, then conditional absolute branch
    jt_write(2, 40);
    jt_write(0, 5);
    jt_write(1, 12'hFFF);
    start_run(10);
    zero_i = 1; flag_en = 1;
    tick();
    flag_en = 0; zero_i = 0;
    abs_br = 1; cond_sel = 2'b01; lut_sel = 2'd2;
    tick();
    check_eq("t2_abs_taken", 32'(prog_ctr), 32'd40);
    abs_br = 0; flag_en = 1;
    tick();
    flag_en = 0; abs_br = 1;
    tick();
    check_eq("t2_abs_not_taken", 32'(prog_ctr), 32'd42);
    $display("conditional abs branch checked");

    // Relative branch wrap and increment wrap
    cond_sel = 2'b00; lut_sel = 2'd0;
    tick();
    abs_br = 0; rel_br = 1; rel_off = 12'hFF8;
    tick();
    check_eq("t3_rel_wrap", 32'(prog_ctr), 32'hFFD);
    rel_br = 0; abs_br = 1; lut_sel = 2'd1;
    tick();
    abs_br = 0;
    tick();
    check_eq("t3_inc_wrap", 32'(prog_ctr), 32'd0);

    // Priority corners
    halt = 1; abs_br = 1; lut_sel = 2'd2;
    tick();
    check_eq("t4_halt_done", 32'(done), 32'd1);
    check_eq("t4_halt_pc", 32'(prog_ctr), 32'd0);
    idle_inputs();
    start_run(200);
    abs_br = 1; rel_br = 1; lut_sel = 2'd2; rel_off = 12'd3;
    tick();
    check_eq("t4_abs_over_rel", 32'(prog_ctr), 32'd40);
    rel_br = 0; lut_sel = 2'd3;
    tick();
    check_eq("t4_lut_oob", 32'(prog_ctr), 32'd41);
    abs_br = 0; sc_i = 1; sc_en = 1;
    tick();
    check_eq("t4_sc_set", 32'(scQ), 32'd1);
    sc_clr = 1;
    tick();
    check_eq("t4_sc_clr_prio", 32'(scQ), 32'd0);
    sc_clr = 0; sc_en = 0; abs_br = 1; cond_sel = 2'b11; lut_sel = 2'd2;
    tick();
    check_eq("t4_cond_sc", 32'(prog_ctr), 32'd44);
    idle_inputs();
    $display("priority corners checked");

    // Handshake
    start_addr = 12'd500; req = 1;
    tick();
    req = 0;
    check_eq("t5_req_in_run", 32'(prog_ctr), 32'd45);
    halt = 1;
    tick();
    halt = 0;
    start_run(300);
    check_eq("t5_restart_done", 32'(done), 32'd0);
    check_eq("t5_restart_pc", 32'(prog_ctr), 32'd300);
    check_eq("t5_restart_cnt", 32'(cycle_cnt), 32'd0);
    tick();
    tick();
    reset = 0;
    #1;
    check_eq("t5_async_pc", 32'(prog_ctr), 32'd0);
    check_eq("t5_async_run", 32'(running), 32'd0);
    model_reset();
    #1;
    reset = 1;
    $display("handshake and async reset checked");

    // Same-cycle table write and read
    start_run(60);
    jt_wr_en = 1; jt_wr_idx = 2'd2; jt_wr_data = 12'd77;
    abs_br = 1; lut_sel = 2'd2;
    tick();
    jt_wr_en = 0;
    check_eq("t6_old_target", 32'(prog_ctr), 32'd0);
    tick();
    check_eq("t6_new_target", 32'(prog_ctr), 32'd77);
    idle_inputs();
    halt = 1;
    tick();
    halt = 0;

    // start_addr == END_ADDR
    start_run(128);
    check_eq("t7_running", 32'(running), 32'd1);
    tick();
    check_eq("t7_done", 32'(done), 32'd1);
    check_eq("t7_pc", 32'(prog_ctr), 32'd128);
    check_eq("t7_cnt", 32'(cycle_cnt), 32'd1);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      idle_inputs();
      if ($urandom_range(0, 2) == 0) begin
        jt_write(int'($urandom_range(0, 2)), int'($urandom_range(100, 140)));
      end
      start_run(($urandom_range(0, 3) != 0) ? int'($urandom_range(100, 127))
                                            : int'($urandom_range(0, 4095)));
      for (int c = 0; c < 60 && m_state == M_RUN; c++) begin
        req        = ($urandom_range(0, 9) == 0);
        start_addr = D'($urandom_range(0, 4095));
        halt       = ($urandom_range(0, 29) == 0);
        abs_br     = ($urandom_range(0, 7) == 0);
        rel_br     = ($urandom_range(0, 5) == 0);
        cond_sel   = 2'($urandom_range(0, 3));
        lut_sel    = LW'($urandom_range(0, 3));
        rel_off    = ($urandom_range(0, 3) == 0) ? D'($urandom_range(0, 4095))
                                                 : D'($urandom_range(0, 31) - 16);
        jt_wr_en   = ($urandom_range(0, 9) == 0);
        jt_wr_idx  = LW'($urandom_range(0, 3));
        jt_wr_data = D'($urandom_range(90, 150));
        zero_i     = 1'($urandom_range(0, 1));
        pari_i     = 1'($urandom_range(0, 1));
        sc_i       = 1'($urandom_range(0, 1));
        flag_en    = 1'($urandom_range(0, 1));
        sc_clr     = ($urandom_range(0, 3) == 0);
        sc_en      = 1'($urandom_range(0, 1));
        tick();
      end
      idle_inputs();
      if (m_state == M_RUN) begin
        halt = 1;
        tick();
        halt = 0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
